// File: rtl/fetch_hazard_ctrl_pkg.sv
// Shared encodings for the fetch-stage hazard controller: FSM states,
// PC source select values and the canonical NOP used when IF/ID is flushed.
package fetch_hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_BR_WAIT  = 2'd1,
    ST_LU_STALL = 2'd2,
    ST_REDIR    = 2'd3
  } hz_state_t;

  localparam int WIDTH_PCSEL_HZ = 1;
  localparam logic [WIDTH_PCSEL_HZ-1:0] PCSEL_SEQ   = 1'b0;
  localparam logic [WIDTH_PCSEL_HZ-1:0] PCSEL_REDIR = 1'b1;

  // addi x0, x0, 0 -- what IF/ID loads when if_id_flush is asserted
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fetch_hazard_ctrl_sat_counter.sv
// Saturating up-counter used for the stall/flush performance counters.
// Holds at all-ones once reached; synchronous clear, asynchronous reset.
module sat_counter #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_inc,
  input  logic                 i_clr,
  output logic [CNT_WIDTH-1:0] o_cnt
);

  logic [CNT_WIDTH-1:0] r_cnt;

  // count up on i_inc, stop at all-ones
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_WIDTH'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard controller: one FSM that drives PC write-enable, PC
// source select and IF/ID, ID/EX control for control transfers, load-use
// stalls, external fetch stops and a redirect that arrives during a stop.
// Handshake note: ex_taken/ex_target are only looked at in a cycle where
// ex_resolve is high and the FSM is in BR_WAIT; ex_resolve is ignored in
// every other state, so EX may hold it without side effects.
module fetch_hazard_ctrl
  import fetch_hazard_ctrl_pkg::*;
#(
  parameter int WIDTH_PC        = 32,
  parameter int LU_STALL_CYCLES = 1,
  parameter int BR_WAIT_MAX     = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stop_IF,
  input  logic                 id_is_branch,
  input  logic                 load_use,
  input  logic                 ex_resolve,
  input  logic                 ex_taken,
  input  logic [WIDTH_PC-1:0]  ex_target,
  output logic                 pc_we,
  output logic                 pc_sel,
  output logic [WIDTH_PC-1:0]  redirect_pc,
  output logic                 if_id_we,
  output logic                 if_id_flush,
  output logic                 id_ex_bubble,
  output logic [1:0]           state_o,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt,
  output logic                 br_timeout
);

  localparam int LU_W   = (LU_STALL_CYCLES > 1) ? $clog2(LU_STALL_CYCLES) : 1;
  localparam int WAIT_W = $clog2(BR_WAIT_MAX + 1);
  localparam logic [LU_W-1:0]   LU_INIT  = LU_W'(LU_STALL_CYCLES - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(BR_WAIT_MAX);

  hz_state_t           r_state, w_state_nxt;
  logic [LU_W-1:0]     r_lu_cnt, w_lu_cnt_nxt;
  logic [WAIT_W-1:0]   r_wait_cnt, w_wait_cnt_nxt;
  logic                r_pend, w_pend_nxt;
  logic                r_pend_taken, w_pend_taken_nxt;
  logic [WIDTH_PC-1:0] r_pend_target, w_pend_target_nxt;
  logic                r_br_timeout, w_timeout_set;

  logic                w_pc_we, w_pc_sel, w_if_id_we, w_if_id_flush, w_id_ex_bubble;
  logic [WIDTH_PC-1:0] w_redirect_pc;
  logic                w_stall_inc, w_flush_inc;

  // state, stall/wait counters, pending redirect and sticky timeout flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ST_RUN;
      r_lu_cnt      <= '0;
      r_wait_cnt    <= '0;
      r_pend        <= 1'b0;
      r_pend_taken  <= 1'b0;
      r_pend_target <= '0;
      r_br_timeout  <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_lu_cnt      <= w_lu_cnt_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
      r_pend        <= w_pend_nxt;
      r_pend_taken  <= w_pend_taken_nxt;
      r_pend_target <= w_pend_target_nxt;
      if (w_timeout_set) r_br_timeout <= 1'b1;
    end
  end

  // next-state and pipeline controls, purely from current state and inputs
  always_comb begin
    w_state_nxt       = r_state;
    w_lu_cnt_nxt      = r_lu_cnt;
    w_wait_cnt_nxt    = r_wait_cnt;
    w_pend_nxt        = r_pend;
    w_pend_taken_nxt  = r_pend_taken;
    w_pend_target_nxt = r_pend_target;
    w_timeout_set     = 1'b0;
    w_pc_we           = 1'b0;
    w_pc_sel          = PCSEL_SEQ;
    w_redirect_pc     = '0;
    w_if_id_we        = 1'b0;
    w_if_id_flush     = 1'b0;
    w_id_ex_bubble    = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (stop_IF) begin
          // freeze PC and IF/ID; nothing else changes
        end else if (load_use) begin
          w_id_ex_bubble = 1'b1;
          w_lu_cnt_nxt   = LU_INIT;
          if (LU_STALL_CYCLES > 1) w_state_nxt = ST_LU_STALL;
        end else if (id_is_branch) begin
          w_if_id_flush  = 1'b1;
          w_wait_cnt_nxt = '0;
          w_state_nxt    = ST_BR_WAIT;
        end else begin
          w_pc_we    = 1'b1;
          w_if_id_we = 1'b1;
        end
      end
      ST_LU_STALL: begin
        w_id_ex_bubble = 1'b1;
        w_lu_cnt_nxt   = r_lu_cnt - LU_W'(1);
        if (r_lu_cnt <= LU_W'(1)) w_state_nxt = ST_RUN;
      end
      ST_BR_WAIT: begin
        if (ex_resolve && !stop_IF) begin
          w_pc_we = 1'b1;
          if (ex_taken) begin
            w_pc_sel      = PCSEL_REDIR;
            w_redirect_pc = ex_target;
          end
          w_state_nxt = ST_RUN;
        end else if (ex_resolve) begin
          // fetch is stopped: remember the outcome and apply it later
          w_if_id_flush     = 1'b1;
          w_pend_nxt        = 1'b1;
          w_pend_taken_nxt  = ex_taken;
          w_pend_target_nxt = ex_target;
          w_state_nxt       = ST_REDIR;
        end else if (r_wait_cnt == WAIT_MAX) begin
          w_timeout_set = 1'b1;
          w_pc_we       = 1'b1;
          w_state_nxt   = ST_RUN;
        end else begin
          w_if_id_flush  = 1'b1;
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_REDIR: begin
        if (stop_IF) begin
          w_if_id_flush = 1'b1;
        end else begin
          w_pc_we = 1'b1;
          if (r_pend && r_pend_taken) begin
            w_pc_sel      = PCSEL_REDIR;
            w_redirect_pc = r_pend_target;
          end
          w_pend_nxt  = 1'b0;
          w_state_nxt = ST_RUN;
        end
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // every control output is forced low while reset is held
  assign pc_we        = w_pc_we & ~rst;
  assign pc_sel       = w_pc_sel & ~rst;
  assign redirect_pc  = rst ? '0 : w_redirect_pc;
  assign if_id_we     = w_if_id_we & ~rst;
  assign if_id_flush  = w_if_id_flush & ~rst;
  assign id_ex_bubble = w_id_ex_bubble & ~rst;
  assign state_o      = r_state;
  assign br_timeout   = r_br_timeout;

  assign w_stall_inc = ~w_pc_we & ~rst;
  assign w_flush_inc = w_if_id_flush & ~rst;

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_stall_inc),
    .i_clr (1'b0),
    .o_cnt (stall_cnt)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_flush_inc),
    .i_clr (1'b0),
    .o_cnt (flush_cnt)
  );

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Bench for fetch_hazard_ctrl: directed vectors, a behavioural model compared
// every cycle, and hand-computed literal expectations for the key scenarios.
`timescale 1ns/1ps
module tb_fetch_hazard_ctrl;

  localparam int W    = 32;
  localparam int LU   = 2;
  localparam int BWM  = 4;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk, rst;
  logic          stop_IF, id_is_branch, load_use, ex_resolve, ex_taken;
  logic [W-1:0]  ex_target;
  logic          pc_we, pc_sel, if_id_we, if_id_flush, id_ex_bubble, br_timeout;
  logic [W-1:0]  redirect_pc;
  logic [1:0]    state_o;
  logic [CW-1:0] stall_cnt, flush_cnt;

  int n_checks = 0;
  int n_errors = 0;

  fetch_hazard_ctrl #(
    .WIDTH_PC(W), .LU_STALL_CYCLES(LU), .BR_WAIT_MAX(BWM), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst), .stop_IF(stop_IF), .id_is_branch(id_is_branch),
    .load_use(load_use), .ex_resolve(ex_resolve), .ex_taken(ex_taken),
    .ex_target(ex_target), .pc_we(pc_we), .pc_sel(pc_sel),
    .redirect_pc(redirect_pc), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
    .id_ex_bubble(id_ex_bubble), .state_o(state_o), .stall_cnt(stall_cnt),
    .flush_cnt(flush_cnt), .br_timeout(br_timeout)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: what fetch is currently waiting on
  bit           m_wait_active;
  int           m_wait_cycles;
  int           m_bubbles;
  bit           m_pend, m_pend_taken, m_timeout;
  logic [W-1:0] m_pend_target;
  int           m_stall, m_flush;

  task automatic model_reset();
    m_wait_active = 0; m_wait_cycles = 0; m_bubbles = 0;
    m_pend = 0; m_pend_taken = 0; m_pend_target = '0; m_timeout = 0;
    m_stall = 0; m_flush = 0;
  endtask

  // compare process: sample mid-cycle, check, then advance the model
  initial begin
    bit e_we, e_sel, e_ifwe, e_fl, e_bub;
    logic [W-1:0] e_rpc;
    int e_state;
    model_reset();
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        model_reset();
        chk("rst_pc_we", pc_we, 0);
        chk("rst_pc_sel", pc_sel, 0);
        chk("rst_redirect_pc", redirect_pc, 0);
        chk("rst_if_id_we", if_id_we, 0);
        chk("rst_if_id_flush", if_id_flush, 0);
        chk("rst_id_ex_bubble", id_ex_bubble, 0);
        chk("rst_state", state_o, 0);
        chk("rst_stall_cnt", stall_cnt, 0);
        chk("rst_flush_cnt", flush_cnt, 0);
        chk("rst_br_timeout", br_timeout, 0);
      end else begin
        e_we = 0; e_sel = 0; e_ifwe = 0; e_fl = 0; e_bub = 0; e_rpc = '0;
        e_state = m_pend ? 3 : (m_bubbles > 0) ? 2 : m_wait_active ? 1 : 0;
        chk("m_stall_cnt", stall_cnt, m_stall);
        chk("m_flush_cnt", flush_cnt, m_flush);
        chk("m_br_timeout", br_timeout, m_timeout);
        chk("m_state", state_o, e_state);
        if (m_pend) begin
          if (stop_IF) e_fl = 1;
          else begin
            e_we = 1; e_sel = m_pend_taken; e_rpc = m_pend_target; m_pend = 0;
          end
        end else if (m_bubbles > 0) begin
          e_bub = 1; m_bubbles--;
        end else if (m_wait_active) begin
          if (ex_resolve && !stop_IF) begin
            e_we = 1; e_sel = ex_taken; e_rpc = ex_target; m_wait_active = 0;
          end else if (ex_resolve) begin
            e_fl = 1; m_pend = 1; m_pend_taken = ex_taken; m_pend_target = ex_target;
            m_wait_active = 0;
          end else if (m_wait_cycles == BWM) begin
            e_we = 1; m_timeout = 1; m_wait_active = 0;
          end else begin
            e_fl = 1; m_wait_cycles++;
          end
        end else begin
          if (stop_IF) begin
            e_we = 0;
          end else if (load_use) begin
            e_bub = 1; m_bubbles = LU - 1;
          end else if (id_is_branch) begin
            e_fl = 1; m_wait_active = 1; m_wait_cycles = 0;
          end else begin
            e_we = 1; e_ifwe = 1;
          end
        end
        chk("m_pc_we", pc_we, e_we);
        chk("m_pc_sel", pc_sel, e_sel);
        if (e_we && e_sel) chk("m_redirect_pc", redirect_pc, e_rpc);
        chk("m_if_id_we", if_id_we, e_ifwe);
        chk("m_if_id_flush", if_id_flush, e_fl);
        chk("m_id_ex_bubble", id_ex_bubble, e_bub);
        if (!e_we && m_stall < CMAX) m_stall++;
        if (e_fl && m_flush < CMAX) m_flush++;
      end
    end
  end

  // driver tasks: apply one cycle of inputs at the falling edge
  task automatic cyc(input bit s, input bit lu, input bit br, input bit res,
                     input bit tk, input logic [W-1:0] tgt);
    @(negedge clk);
    stop_IF = s; load_use = lu; id_is_branch = br;
    ex_resolve = res; ex_taken = tk; ex_target = tgt;
    #4;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 0, '0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    stop_IF = 0; load_use = 0; id_is_branch = 0;
    ex_resolve = 0; ex_taken = 0; ex_target = '0;
    @(negedge clk);
    rst = 0;
  endtask

  // directed scenarios
  initial begin
    rst = 1;
    stop_IF = 0; load_use = 0; id_is_branch = 0;
    ex_resolve = 0; ex_taken = 0; ex_target = '0;
    repeat (2) @(negedge clk);
    rst = 0;

    // T1: idle after release, then asynchronous reset in the middle of BR_WAIT
    idle();
    chk("t1_pc_we", pc_we, 1);
    chk("t1_pc_sel", pc_sel, 0);
    chk("t1_state", state_o, 0);
    cyc(0, 0, 1, 0, 0, '0);
    idle();
    chk("t1_in_br_wait", state_o, 1);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("t1_async_state", state_o, 0);
    chk("t1_async_flush", if_id_flush, 0);
    chk("t1_async_flush_cnt", flush_cnt, 0);
    chk("t1_async_stall_cnt", stall_cnt, 0);
    @(negedge clk);
    #4;
    @(negedge clk);
    rst = 0;
    idle();
    chk("t1_restart_pc_we", pc_we, 1);
    chk("t1_restart_pc_sel", pc_sel, 0);

    // ex_resolve outside BR_WAIT does nothing
    cyc(0, 0, 0, 1, 1, 32'h3000);
    chk("ign_resolve_pc_sel", pc_sel, 0);
    chk("ign_resolve_pc_we", pc_we, 1);

    // T2: taken branch
    do_reset();
    cyc(0, 0, 1, 0, 0, '0);
    chk("t2_c0_pc_we", pc_we, 0);
    chk("t2_c0_flush", if_id_flush, 1);
    cyc(0, 0, 0, 1, 1, 32'h80);
    chk("t2_c1_pc_we", pc_we, 1);
    chk("t2_c1_pc_sel", pc_sel, 1);
    chk("t2_c1_redirect", redirect_pc, 32'h80);
    idle();
    chk("t2_c2_state", state_o, 0);
    chk("t2_c2_flush_cnt", flush_cnt, 1);

    // T3: load-use, two bubbles
    do_reset();
    cyc(0, 1, 0, 0, 0, '0);
    chk("t3_c0_bubble", id_ex_bubble, 1);
    chk("t3_c0_pc_we", pc_we, 0);
    idle();
    chk("t3_c1_bubble", id_ex_bubble, 1);
    chk("t3_c1_state", state_o, 2);
    idle();
    chk("t3_c2_bubble", id_ex_bubble, 0);
    chk("t3_c2_pc_we", pc_we, 1);
    chk("t3_c2_stall_cnt", stall_cnt, 2);

    // RUN priority: stop_IF over load_use over branch
    cyc(1, 1, 1, 0, 0, '0);
    chk("prio_stop_bubble", id_ex_bubble, 0);
    chk("prio_stop_flush", if_id_flush, 0);
    cyc(0, 1, 1, 0, 0, '0);
    chk("prio_lu_bubble", id_ex_bubble, 1);
    chk("prio_lu_flush", if_id_flush, 0);
    idle();
    idle();
    // not-taken resolve returns to sequential fetch
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, '0);
    chk("nt_pc_we", pc_we, 1);
    chk("nt_pc_sel", pc_sel, 0);

    // T4: resolve while fetch is stopped, redirect applied afterwards
    do_reset();
    cyc(0, 0, 1, 0, 0, '0);
    idle();
    cyc(1, 0, 0, 1, 1, 32'h1000);
    chk("t4_resolve_pc_we", pc_we, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 1, 1, 32'h2000);
      chk("t4_redir_state", state_o, 3);
      chk("t4_redir_pc_we", pc_we, 0);
    end
    idle();
    chk("t4_exit_pc_we", pc_we, 1);
    chk("t4_exit_pc_sel", pc_sel, 1);
    chk("t4_exit_redirect", redirect_pc, 32'h1000);
    idle();
    chk("t4_after_state", state_o, 0);
    chk("t4_after_stall_cnt", stall_cnt, 6);

    // T5: BR_WAIT timeout and sticky flag
    do_reset();
    cyc(0, 0, 1, 0, 0, '0);
    for (int i = 0; i < 4; i++) begin
      idle();
      chk("t5_wait_pc_we", pc_we, 0);
    end
    idle();
    chk("t5_to_pc_we", pc_we, 1);
    chk("t5_to_pc_sel", pc_sel, 0);
    idle();
    chk("t5_flag_set", br_timeout, 1);
    chk("t5_state_run", state_o, 0);
    cyc(0, 0, 1, 0, 0, '0);
    cyc(0, 0, 0, 1, 0, '0);
    idle();
    chk("t5_flag_sticky", br_timeout, 1);
    do_reset();
    idle();
    chk("t5_flag_cleared", br_timeout, 0);

    // T6: stall counter saturates, flush counter untouched
    do_reset();
    repeat (20) cyc(1, 0, 0, 0, 0, '0);
    idle();
    chk("t6_stall_sat", stall_cnt, 15);
    chk("t6_flush_zero", flush_cnt, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
